// File: rtl/ls_down_timer_if.sv
// Handshake/bus bundle for ls_down_timer: preset, enables, mode and the count/status outputs.
// The timer takes the slave side of this interface; the driver takes the master side.
interface ls_down_timer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] D;
    logic             LOAD_n;
    logic             ENP;
    logic             ENT;
    logic             MODE;
    logic [WIDTH-1:0] Q;
    logic             BUSY;
    logic             DONE;
    logic             RBO;

    modport master (
        output D, LOAD_n, ENP, ENT, MODE,
        input  Q, BUSY, DONE, RBO
    );

    modport slave (
        input  D, LOAD_n, ENP, ENT, MODE,
        output Q, BUSY, DONE, RBO
    );
endinterface

// File: rtl/ls_down_timer.sv
// Presettable cascadable down timer, one-shot or periodic, with ripple-borrow output.
// Define DOWN_TIMER_STICKY_DONE_EN to hold DONE high until the next load instead of pulsing it.
module ls_down_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic          CLK,
    input  logic          CLR_n,
    ls_down_timer_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;
    logic             cnt_en;
    logic             at_zero;
    logic             busy;

    assign cnt_en  = bus.ENP & bus.ENT;
    assign at_zero = (q_q == '0);
    assign busy    = (state_q == RUN);

    // State, count, reload and DONE registers
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
        end
    end

    // Next-state: load beats counting; the terminal event reloads or drops to IDLE
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
`ifdef DOWN_TIMER_STICKY_DONE_EN
        done_d  = done_q;
`else
        done_d  = 1'b0;
`endif
        if (!bus.LOAD_n) begin
            q_d     = bus.D;
            r_d     = bus.D;
            state_d = RUN;
            done_d  = 1'b0;
        end else if ((state_q == RUN) && cnt_en) begin
            if (at_zero) begin
                done_d = 1'b1;
                if (bus.MODE) begin
                    q_d = r_q;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                q_d = q_q - WIDTH'(1);
            end
        end
    end

    assign bus.Q    = q_q;
    assign bus.BUSY = busy;
    assign bus.DONE = done_q;
    // Borrow is combinational so a following stage sees it within the same cycle
    assign bus.RBO  = at_zero & bus.ENT & busy;
endmodule

// File: tb/tb_ls_down_timer.sv
// Self-checking bench for ls_down_timer: directed scenarios, randomized traffic against a
// behavioural model, and a two-stage cascade through RBO->ENT.
module tb_ls_down_timer;
    localparam int unsigned WIDTH = 4;
`ifdef DOWN_TIMER_STICKY_DONE_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic CLR_n = 1'b0;

    ls_down_timer_if #(.WIDTH(WIDTH)) tb_if ();
    ls_down_timer_if #(.WIDTH(WIDTH)) lo_if ();
    ls_down_timer_if #(.WIDTH(WIDTH)) hi_if ();

    ls_down_timer #(.WIDTH(WIDTH)) dut  (.CLK(CLK), .CLR_n(CLR_n), .bus(tb_if.slave));
    ls_down_timer #(.WIDTH(WIDTH)) u_lo (.CLK(CLK), .CLR_n(CLR_n), .bus(lo_if.slave));
    ls_down_timer #(.WIDTH(WIDTH)) u_hi (.CLK(CLK), .CLR_n(CLR_n), .bus(hi_if.slave));

    assign hi_if.ENT = lo_if.RBO;

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the single timer
    int m_q;
    int m_r;
    bit m_run;
    bit m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_r = 0; m_run = 1'b0; m_done = 1'b0;
    endtask

    task automatic compare();
        chk("q",    32'(tb_if.Q),    32'(m_q));
        chk("busy", 32'(tb_if.BUSY), 32'(m_run));
        chk("done", 32'(tb_if.DONE), 32'(m_done));
        chk("rbo",  32'(tb_if.RBO),  32'((m_q == 0) && (tb_if.ENT === 1'b1) && m_run));
    endtask

    // Advance the model by one rising edge using the inputs currently presented
    task automatic model_edge();
        bit term;
        term = 1'b0;
        if (!CLR_n) begin
            model_reset();
        end else if (!tb_if.LOAD_n) begin
            m_q = int'(tb_if.D); m_r = int'(tb_if.D); m_run = 1'b1; m_done = 1'b0;
        end else begin
            if (m_run && tb_if.ENP && tb_if.ENT) begin
                if (m_q == 0) begin
                    term = 1'b1;
                    if (tb_if.MODE) m_q = m_r;
                    else            m_run = 1'b0;
                end else begin
                    m_q = m_q - 1;
                end
            end
            m_done = term ? 1'b1 : (STICKY ? m_done : 1'b0);
        end
    endtask

    // Present inputs, compare outputs, then step one clock
    task automatic cyc(input bit ld_n, input int d, input bit enp, input bit ent, input bit mode);
        tb_if.LOAD_n = ld_n;
        tb_if.D      = WIDTH'(d);
        tb_if.ENP    = enp;
        tb_if.ENT    = ent;
        tb_if.MODE   = mode;
        #1;
        compare();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    int exp_q3    [7] = '{1, 0, 2, 1, 0, 2, 1};
    int exp_d3    [7] = '{0, 0, 1, 0, 0, 1, 0};
    int exp_d3s   [7] = '{0, 0, 1, 1, 1, 1, 1};
    int n;

    initial begin
        tb_if.LOAD_n = 1'b1; tb_if.D = '0; tb_if.ENP = 1'b0; tb_if.ENT = 1'b0; tb_if.MODE = 1'b0;
        lo_if.LOAD_n = 1'b1; lo_if.D = '0; lo_if.ENP = 1'b0; lo_if.ENT = 1'b1; lo_if.MODE = 1'b0;
        hi_if.LOAD_n = 1'b1; hi_if.D = '0; hi_if.ENP = 1'b0; hi_if.MODE = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;

        // Reset state, then enabled counting without a load stays at 0
        repeat (2) cyc(1'b1, 0, 1'b1, 1'b1, 1'b0);
        chk("rst_q", 32'(tb_if.Q), 32'd0);
        chk("rst_busy", 32'(tb_if.BUSY), 32'd0);
        chk("rst_done", 32'(tb_if.DONE), 32'd0);
        chk("rst_rbo", 32'(tb_if.RBO), 32'd0);
        CLR_n = 1'b1;
        repeat (3) cyc(1'b1, 0, 1'b1, 1'b1, 1'b1);
        chk("noload_q", 32'(tb_if.Q), 32'd0);
        chk("noload_busy", 32'(tb_if.BUSY), 32'd0);

        // One-shot from 3
        cyc(1'b0, 3, 1'b1, 1'b1, 1'b0);
        chk("os_load_q", 32'(tb_if.Q), 32'd3);
        chk("os_load_busy", 32'(tb_if.BUSY), 32'd1);
        for (int e = 2; e >= 0; e--) begin
            cyc(1'b1, 0, 1'b1, 1'b1, 1'b0);
            chk("os_q", 32'(tb_if.Q), 32'(e));
            chk("os_done_low", 32'(tb_if.DONE), 32'd0);
        end
        chk("os_rbo_zero", 32'(tb_if.RBO), 32'd1);
        cyc(1'b1, 0, 1'b1, 1'b1, 1'b0);
        chk("os_done", 32'(tb_if.DONE), 32'd1);
        chk("os_busy_end", 32'(tb_if.BUSY), 32'd0);
        chk("os_q_end", 32'(tb_if.Q), 32'd0);
        cyc(1'b1, 0, 1'b1, 1'b1, 1'b0);
        chk("os_done_after", 32'(tb_if.DONE), STICKY ? 32'd1 : 32'd0);
        chk("os_idle_rbo", 32'(tb_if.RBO), 32'd0);

        // Periodic from 2
        cyc(1'b0, 2, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 0, 1'b1, 1'b1, 1'b1);
            chk("per_q", 32'(tb_if.Q), 32'(exp_q3[i]));
            chk("per_done", 32'(tb_if.DONE), 32'(STICKY ? exp_d3s[i] : exp_d3[i]));
            chk("per_rbo", 32'(tb_if.RBO), 32'(exp_q3[i] == 0));
        end

        // Independent enables at Q=5
        cyc(1'b0, 5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("en00", 32'(tb_if.Q), 32'd5);
        cyc(1'b1, 0, 1'b1, 1'b0, 1'b0);
        chk("en10", 32'(tb_if.Q), 32'd5);
        cyc(1'b1, 0, 1'b0, 1'b1, 1'b0);
        chk("en01", 32'(tb_if.Q), 32'd5);
        cyc(1'b1, 0, 1'b1, 1'b1, 1'b0);
        chk("en11", 32'(tb_if.Q), 32'd4);
        repeat (4) cyc(1'b1, 0, 1'b1, 1'b1, 1'b0);
        chk("en_zero", 32'(tb_if.Q), 32'd0);
        tb_if.ENP = 1'b0;
        tb_if.ENT = 1'b0;
        #1;
        chk("rbo_ent0", 32'(tb_if.RBO), 32'd0);
        tb_if.ENT = 1'b1;
        #1;
        chk("rbo_ent1", 32'(tb_if.RBO), 32'd1);

        // Load colliding with a terminal event, then asynchronous reset mid-count
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 9, 1'b1, 1'b1, 1'b0);
        chk("col_q", 32'(tb_if.Q), 32'd9);
        chk("col_done", 32'(tb_if.DONE), 32'd0);
        chk("col_busy", 32'(tb_if.BUSY), 32'd1);
        repeat (3) cyc(1'b1, 0, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_q", 32'(tb_if.Q), 32'd6);
        #2;
        CLR_n = 1'b0;
        #1;
        model_reset();
        chk("arst_q", 32'(tb_if.Q), 32'd0);
        chk("arst_busy", 32'(tb_if.BUSY), 32'd0);
        chk("arst_done", 32'(tb_if.DONE), 32'd0);
        chk("arst_rbo", 32'(tb_if.RBO), 32'd0);
        cyc(1'b1, 0, 1'b1, 1'b1, 1'b0);
        CLR_n = 1'b1;
        repeat (2) cyc(1'b1, 0, 1'b1, 1'b1, 1'b0);
        chk("post_rst_q", 32'(tb_if.Q), 32'd0);
        chk("post_rst_busy", 32'(tb_if.BUSY), 32'd0);

        // DONE after a one-shot from 1, then cleared by the next load
        cyc(1'b0, 1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 0, 1'b1, 1'b1, 1'b0);
        chk("sd_rise", 32'(tb_if.DONE), 32'd1);
        repeat (2) cyc(1'b1, 0, 1'b1, 1'b1, 1'b0);
        chk("sd_hold", 32'(tb_if.DONE), STICKY ? 32'd1 : 32'd0);
        cyc(1'b0, 4, 1'b0, 1'b0, 1'b0);
        chk("sd_clear", 32'(tb_if.DONE), 32'd0);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 1500; i++) begin
            if (CLR_n == 1'b0) begin
                CLR_n = 1'b1;
            end else if ($urandom_range(149) == 0) begin
                #2;
                CLR_n = 1'b0;
                #1;
                model_reset();
                compare();
            end
            cyc(($urandom_range(7) != 0), int'($urandom_range(15)), ($urandom_range(3) != 0),
                ($urandom_range(3) != 0), bit'($urandom_range(1)));
        end
        CLR_n = 1'b1;
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);

        // Two-stage cascade counting 0x12 with the low stage reloading 0xF
        lo_if.D = 4'hF; lo_if.MODE = 1'b1; lo_if.LOAD_n = 1'b0;
        hi_if.D = 4'h1; hi_if.MODE = 1'b0; hi_if.LOAD_n = 1'b0;
        @(posedge CLK);
        #1;
        lo_if.LOAD_n = 1'b1;
        hi_if.LOAD_n = 1'b1;
        lo_if.ENP    = 1'b1;
        repeat (13) @(posedge CLK);
        #1;
        chk("cas_lo_q", 32'(lo_if.Q), 32'd2);
        chk("cas_hi_q", 32'(hi_if.Q), 32'd1);
        hi_if.ENP = 1'b1;
        n = 0;
        while ((hi_if.BUSY === 1'b1) && (n < 100)) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("cas_cycles", 32'(n), 32'd19);
        chk("cas_done", 32'(hi_if.DONE), 32'd1);
        chk("cas_hi_end", 32'(hi_if.Q), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
